// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter arbiter slice.
package shift_pkg;

  localparam int unsigned SHIFT_W = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 2;

  // bit1 = ctl1 (direction), bit0 = ctl0 (sign-extend)
  localparam logic [OP_W-1:0] OP_SLL = 2'b00;
  localparam logic [OP_W-1:0] OP_SRL = 2'b10;
  localparam logic [OP_W-1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  // Operand register payload handed to the shifter
  typedef struct packed {
    logic [SHIFT_W-1:0] a;
    logic [SHIFT_W-1:0] b;
    logic [OP_W-1:0]    op;
  } shift_req_t;

  // Sign-extend only means something for right shifts; left shifts clear it
  function automatic logic [OP_W-1:0] sanitize_op(input logic [OP_W-1:0] op);
    return op[1] ? op : OP_SLL;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response handshakes of both requesters plus the shifter hookup.
interface shift_arbiter_if;
  import shift_pkg::*;

  logic               req0_valid;
  logic               req0_ready;
  logic [SHIFT_W-1:0] req0_a;
  logic [SHIFT_W-1:0] req0_b;
  logic [OP_W-1:0]    req0_op;

  logic               req1_valid;
  logic               req1_ready;
  logic [SHIFT_W-1:0] req1_a;
  logic [SHIFT_W-1:0] req1_b;
  logic [OP_W-1:0]    req1_op;

  logic               rsp0_valid;
  logic               rsp0_ready;
  logic [SHIFT_W-1:0] rsp0_data;

  logic               rsp1_valid;
  logic               rsp1_ready;
  logic [SHIFT_W-1:0] rsp1_data;

  logic [SHIFT_W-1:0] sh_a;
  logic [SHIFT_W-1:0] sh_b;
  logic               sh_ctl0;
  logic               sh_ctl1;
  logic [SHIFT_W-1:0] sh_out;

  // Requesters and the shifter together
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready,
    input  sh_a, sh_b, sh_ctl0, sh_ctl1,
    output sh_out
  );

  // The arbiter
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready,
    output sh_a, sh_b, sh_ctl0, sh_ctl1,
    input  sh_out
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant with the last-served register.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_c,
  output logic       any_c
);

  logic last_q;

  // Lone requester wins; on contention the one not served last wins
  always_comb begin
    any_c = |req;
    gnt_c = req[1];
    if (req == 2'b11) begin
      gnt_c = ~last_q;
    end
  end

  // Remember who was served; reset favours requester 0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= gnt_c;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one combinational barrel shifter between two requesters, one op in flight.
module shift_arbiter
  import shift_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  shift_arbiter_if.slave  bus
);

  state_e             state_q, state_d;
  shift_req_t         op_q, op_d;
  logic               tag_q, tag_d;
  logic [SHIFT_W-1:0] res_q, res_d;
  logic [1:0]         rsp_vld_q, rsp_vld_d;

  logic       gnt_c;
  logic       any_c;
  logic       take_c;
  logic [1:0] req_vld_c;
  logic [1:0] rsp_rdy_c;

  assign req_vld_c = {bus.req1_valid, bus.req0_valid};
  assign rsp_rdy_c = {bus.rsp1_ready, bus.rsp0_ready};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vld_c),
    .take  (take_c),
    .gnt_c (gnt_c),
    .any_c (any_c)
  );

  // Next state, operand capture, result capture and response flags
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tag_d     = tag_q;
    res_d     = res_q;
    rsp_vld_d = rsp_vld_q;
    take_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n gate keeps ready low while reset is held
        if (any_c && rst_n) begin
          take_c  = 1'b1;
          tag_d   = gnt_c;
          state_d = ST_EXEC;
          if (gnt_c) begin
            op_d = '{a: bus.req1_a, b: bus.req1_b, op: sanitize_op(bus.req1_op)};
          end else begin
            op_d = '{a: bus.req0_a, b: bus.req0_b, op: sanitize_op(bus.req0_op)};
          end
        end
      end
      ST_EXEC: begin
        res_d            = bus.sh_out;
        rsp_vld_d[tag_q] = 1'b1;
        state_d          = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_rdy_c[tag_q]) begin
          rsp_vld_d = 2'b00;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      tag_q     <= 1'b0;
      res_q     <= '0;
      rsp_vld_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      res_q     <= res_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign bus.req0_ready = take_c & ~gnt_c;
  assign bus.req1_ready = take_c & gnt_c;
  assign bus.rsp0_valid = rsp_vld_q[0];
  assign bus.rsp1_valid = rsp_vld_q[1];
  assign bus.rsp0_data  = res_q;
  assign bus.rsp1_data  = res_q;
  assign bus.sh_a       = op_q.a;
  assign bus.sh_b       = op_q.b;
  assign bus.sh_ctl0    = op_q.op[0];
  assign bus.sh_ctl1    = op_q.op[1];

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural barrel shifter beside it.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_arbiter_if bif ();

  shift_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shifter: honours only the low shift-amount bits
  logic [SHAMT_W-1:0] shamt;
  assign shamt = bif.sh_b[SHAMT_W-1:0];
  always_comb begin
    case ({bif.sh_ctl1, bif.sh_ctl0})
      OP_SRA:  bif.sh_out = 32'($signed(bif.sh_a) >>> shamt);
      OP_SRL:  bif.sh_out = bif.sh_a >> shamt;
      default: bif.sh_out = bif.sh_a << shamt;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bif.req0_valid = 1'b0; bif.req0_a = '0; bif.req0_b = '0; bif.req0_op = OP_SLL;
    bif.req1_valid = 1'b0; bif.req1_a = '0; bif.req1_b = '0; bif.req1_op = OP_SLL;
    bif.rsp0_ready = 1'b0; bif.rsp1_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req0_ready", 32'(bif.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bif.req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(bif.rsp1_valid), 32'd0);
    chk("rst_sh_a", bif.sh_a, 32'd0);
    chk("rst_sh_b", bif.sh_b, 32'd0);
    chk("rst_sh_ctl", 32'({bif.sh_ctl1, bif.sh_ctl0}), 32'd0);
    chk("rst_rsp0_data", bif.rsp0_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Contention: grants must alternate 0,1,0,1 with one accept per 3 cycles
    bif.req0_valid = 1'b1; bif.req0_a = 32'h1; bif.req0_b = 32'd1; bif.req0_op = OP_SLL;
    bif.req1_valid = 1'b1; bif.req1_a = 32'h1; bif.req1_b = 32'd1; bif.req1_op = OP_SLL;
    bif.rsp0_ready = 1'b1; bif.rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic g;
      g = (i % 2) == 1;
      chk("cont_req0_ready", 32'(bif.req0_ready), 32'(!g));
      chk("cont_req1_ready", 32'(bif.req1_ready), 32'(g));
      tick();
      chk("cont_exec_ready", 32'({bif.req1_ready, bif.req0_ready}), 32'd0);
      tick();
      chk("cont_rsp0_valid", 32'(bif.rsp0_valid), 32'(!g));
      chk("cont_rsp1_valid", 32'(bif.rsp1_valid), 32'(g));
      chk("cont_rsp_data", g ? bif.rsp1_data : bif.rsp0_data, 32'h2);
      tick();
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    #1;

    // Single request on requester 0
    bif.req0_valid = 1'b1; bif.req0_a = 32'h1; bif.req0_b = 32'd4; bif.req0_op = OP_SLL;
    #1;
    chk("single_req0_ready", 32'(bif.req0_ready), 32'd1);
    chk("single_req1_ready", 32'(bif.req1_ready), 32'd0);
    tick();
    bif.req0_valid = 1'b0;
    #1;
    chk("single_exec_ready", 32'(bif.req0_ready), 32'd0);
    chk("single_sh_a", bif.sh_a, 32'h1);
    chk("single_sh_b", bif.sh_b, 32'd4);
    chk("single_exec_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
    tick();
    chk("single_rsp0_valid", 32'(bif.rsp0_valid), 32'd1);
    chk("single_rsp0_data", bif.rsp0_data, 32'h10);
    chk("single_rsp1_valid", 32'(bif.rsp1_valid), 32'd0);
    tick();
    chk("single_done_rsp0", 32'(bif.rsp0_valid), 32'd0);
    chk("single_done_rsp1", 32'(bif.rsp1_valid), 32'd0);

    // Backpressure on requester 1 with an arithmetic right shift
    bif.rsp1_ready = 1'b0;
    bif.req1_valid = 1'b1; bif.req1_a = 32'h8000_0000; bif.req1_b = 32'd4; bif.req1_op = OP_SRA;
    #1;
    chk("bp_req1_ready", 32'(bif.req1_ready), 32'd1);
    tick();
    bif.req1_valid = 1'b0;
    bif.req0_valid = 1'b1; bif.req0_a = 32'h5; bif.req0_b = 32'd1; bif.req0_op = OP_SLL;
    #1;
    chk("bp_exec_req0_ready", 32'(bif.req0_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp1_valid", 32'(bif.rsp1_valid), 32'd1);
      chk("bp_rsp1_data", bif.rsp1_data, 32'hF800_0000);
      chk("bp_req0_ready", 32'(bif.req0_ready), 32'd0);
      chk("bp_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
      tick();
    end
    bif.rsp1_ready = 1'b1;
    tick();
    chk("bp_done_rsp1_valid", 32'(bif.rsp1_valid), 32'd0);
    chk("bp_idle_req0_ready", 32'(bif.req0_ready), 32'd1);
    bif.req0_valid = 1'b0;
    #1;

    // Op sanitising and shift-amount masking: op 01, b=0x24 shifts left by 4
    bif.req0_valid = 1'b1; bif.req0_a = 32'h3; bif.req0_b = 32'h24; bif.req0_op = 2'b01;
    #1;
    chk("san_req0_ready", 32'(bif.req0_ready), 32'd1);
    tick();
    bif.req0_valid = 1'b0;
    #1;
    chk("san_sh_ctl0", 32'(bif.sh_ctl0), 32'd0);
    chk("san_sh_ctl1", 32'(bif.sh_ctl1), 32'd0);
    chk("san_sh_b", bif.sh_b, 32'h24);
    chk("san_sh_a", bif.sh_a, 32'h3);
    tick();
    chk("san_rsp0_valid", 32'(bif.rsp0_valid), 32'd1);
    chk("san_rsp0_data", bif.rsp0_data, 32'h30);
    tick();

    // Reset while the op is in EXEC
    bif.req1_valid = 1'b1; bif.req1_a = 32'h1; bif.req1_b = 32'd1; bif.req1_op = OP_SLL;
    #1;
    chk("mid_req1_ready", 32'(bif.req1_ready), 32'd1);
    tick();
    bif.req0_valid = 1'b1; bif.req0_a = 32'h1; bif.req0_b = 32'd1; bif.req0_op = OP_SLL;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_req0_ready", 32'(bif.req0_ready), 32'd0);
      chk("mid_rst_req1_ready", 32'(bif.req1_ready), 32'd0);
      chk("mid_rst_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
      chk("mid_rst_rsp1_valid", 32'(bif.rsp1_valid), 32'd0);
      chk("mid_rst_sh_a", bif.sh_a, 32'd0);
      chk("mid_rst_sh_b", bif.sh_b, 32'd0);
      chk("mid_rst_sh_ctl", 32'({bif.sh_ctl1, bif.sh_ctl0}), 32'd0);
      chk("mid_rst_rsp1_data", bif.rsp1_data, 32'd0);
      tick();
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
      chk("post_rst_rsp1_valid", 32'(bif.rsp1_valid), 32'd0);
    end
    bif.req0_valid = 1'b1;
    bif.req1_valid = 1'b1;
    #1;
    chk("post_rst_req0_first", 32'(bif.req0_ready), 32'd1);
    chk("post_rst_req1_wait", 32'(bif.req1_ready), 32'd0);
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
